frame_loader: RTL and testbench
===============================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 The module SHALL have parameter ROWS, default 16, number of matrix rows.
REQ-002 The module SHALL have parameter COLS, default 16, number of matrix columns.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  a row word is offered on in_data.
REQ-006 in_ready  output  1  the loader accepts in_data this cycle.
REQ-007 in_data  input  [0:COLS-1]  one row word; bit 0 is column 0 (leftmost).
REQ-008 in_sof  input  1  the offered word is row 0 of a new frame.
REQ-009 frame_sync  input  1  a display scan completed; a buffer swap is permitted this cycle.
REQ-010 mat  output  [0:ROWS*COLS-1]  front frame; row r occupies bits r*COLS to r*COLS+COLS-1.
REQ-011 frame_done  output  1  one-cycle pulse, the cycle after a swap.
REQ-012 sync_err  output  1  one-cycle pulse, a partial frame was discarded.
REQ-013 sync_err_sticky  output  1  set by any sync_err pulse; cleared only by reset.

Function
REQ-014 The module SHALL implement two states: FILL and PENDING.
REQ-015 in_ready SHALL be 1 in FILL and 0 in PENDING, decoded from state only, never from in_valid.
REQ-016 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 An accepted word SHALL be written to back-buffer row row_idx, after which row_idx increments.
REQ-018 A word at row_idx=0 SHALL be accepted as row 0 whether or not in_sof=1.
REQ-019 An accepted word with in_sof=1 at row_idx!=0 SHALL be written to row 0, set row_idx=1, and pulse sync_err the next cycle; earlier rows of the partial frame SHALL remain in the back buffer but are overwritten before the next swap.
REQ-020 Acceptance of row ROWS-1 SHALL set row_idx=0 and move FILL->PENDING.
REQ-021 In PENDING, frame_sync=1 SHALL copy the whole back buffer to mat on that edge and move to FILL.
REQ-022 frame_done SHALL be 1 for exactly the cycle following a swap edge.
REQ-023 frame_sync in FILL SHALL be ignored; mat SHALL change only on a swap edge.
REQ-024 Latency SHALL be: last row accepted at edge N, swap no earlier than edge N+1, in_ready=1 from the cycle after the swap.
REQ-025 A frame_sync held high across PENDING entry SHALL swap at the first edge in PENDING.
REQ-026 in_data SHALL be sampled only on accept; the back buffer SHALL never change while in PENDING.

Reset
REQ-027 While rst_n=0, the module SHALL hold: state=FILL, row_idx=0, mat=0 (blank), back buffer=0, frame_done=0, sync_err=0, sync_err_sticky=0, in_ready=1.
REQ-028 Reset mid-frame or in PENDING SHALL discard the back buffer and leave mat blank; no swap SHALL occur on the release edge.

Structure
REQ-029 Package display_pkg SHALL hold ROWS_DEF=16, COLS_DEF=16, FRAME_BITS=256, and the loader state enum {FILL, PENDING}.
REQ-030 The back buffer SHALL be one sub-module, frame_bank: ROWS x COLS storage, one row-write port (row index, data, write enable), full-frame parallel read, async active-low clear.
REQ-031 The row counter, FSM, front register and flags SHALL live in frame_loader.

Verification
REQ-032 Reset, then 16 words 16'h2040, 16'h28A0, ..., 16'h0040 with in_valid=1, in_sof on the first, frame_sync=0 -> in_ready=0 after word 16, mat stays all-zero.
REQ-033 From the previous state, pulse frame_sync one cycle -> mat[0:15]=16'h2040, mat[240:255]=16'h0040, frame_done high for exactly one cycle, in_ready=1 the following cycle.
REQ-034 Send 5 words, then a word 16'hFFFF with in_sof=1 -> sync_err pulses once, sync_err_sticky=1; after 15 more words and frame_sync, mat[0:15]=16'hFFFF.
REQ-035 In FILL, hold frame_sync=1 for 20 cycles with row_idx=7 -> mat unchanged, frame_done never asserted.
REQ-036 Assert rst_n=0 asynchronously while in PENDING with a full back buffer -> mat=0, in_ready=1 immediately; after release, frame_sync gives no frame_done.
REQ-037 Toggle in_valid randomly during 3 back-to-back frames with frame_sync every 40 cycles -> each frame appears intact in mat, no row lost or duplicated, frame_done count=3.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and loader state encoding for the display frame path.
package display_pkg;
    localparam int ROWS_DEF   = 16;
    localparam int COLS_DEF   = 16;
    localparam int FRAME_BITS = ROWS_DEF * COLS_DEF;

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        PENDING = 1'b1
    } ld_state_e;
endpackage

// File: rtl/frame_loader_if.sv
// Row-word stream into the frame loader: valid/ready handshake plus start-of-frame marker.
interface frame_loader_if import display_pkg::*; #(
    parameter int COLS = COLS_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic            in_sof;
    logic [0:COLS-1] in_data;

    modport master (output in_valid, in_data, in_sof, input in_ready);
    modport slave  (input in_valid, in_data, in_sof, output in_ready);
endinterface

// File: rtl/frame_bank.sv
// Back-buffer storage: one row written per cycle, whole frame visible in parallel.
module frame_bank import display_pkg::*; #(
    parameter int  ROWS = ROWS_DEF,
    parameter int  COLS = COLS_DEF,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [RW-1:0]        wr_row,
    input  logic [0:COLS-1]      wr_data,
    output logic [0:ROWS*COLS-1] frame
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [0:COLS-1] row_q;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n)
                row_q <= '0;
            else if (wr_en && wr_row == RW'(r))
                row_q <= wr_data;
        end

        assign frame[r*COLS +: COLS] = row_q;
    end
endmodule

// File: rtl/frame_loader.sv
// Double-buffered frame loader: rows fill the back bank, frame_sync swaps it to the front.
module frame_loader import display_pkg::*; #(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                 clock,
    input  logic                 rst_n,
    frame_loader_if.slave        in_if,
    input  logic                 frame_sync,
    output logic [0:ROWS*COLS-1] mat,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 sync_err_sticky
);
    localparam int            RW         = $clog2(ROWS);
    localparam logic [0:0]    ST_FILL    = FILL;
    localparam logic [0:0]    ST_PENDING = PENDING;
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

    logic [0:0]           state;
    logic [RW-1:0]        row_idx;
    logic [RW-1:0]        wr_row;
    logic                 accept;
    logic                 restart;
    logic                 last;
    logic                 swap;
    logic [0:ROWS*COLS-1] back;

    assign in_if.in_ready = (state == ST_FILL);
    assign accept         = in_if.in_valid && in_if.in_ready;
    // An sof mid-frame abandons the partial frame and restarts at row 0.
    assign restart        = in_if.in_sof && (row_idx != '0);
    assign wr_row         = in_if.in_sof ? '0 : row_idx;
    assign last           = (wr_row == LAST_ROW);
    assign swap           = (state == ST_PENDING) && frame_sync;

    frame_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_row  (wr_row),
        .wr_data (in_if.in_data),
        .frame   (back)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_FILL;
            row_idx         <= '0;
            mat             <= '0;
            frame_done      <= 1'b0;
            sync_err        <= 1'b0;
            sync_err_sticky <= 1'b0;
        end else begin
            frame_done <= swap;
            sync_err   <= accept && restart;
            if (accept && restart)
                sync_err_sticky <= 1'b1;
            if (accept) begin
                row_idx <= last ? '0 : wr_row + RW'(1);
                if (last)
                    state <= ST_PENDING;
            end
            if (swap) begin
                mat   <= back;
                state <= ST_FILL;
            end
        end
    end
endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader with a frame-level reference model and directed anchors.
module tb_frame_loader;
    import display_pkg::*;
    localparam int ROWS = ROWS_DEF;
    localparam int COLS = COLS_DEF;
    localparam int FB   = ROWS * COLS;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          frame_sync;
    logic [0:FB-1] mat;
    logic          frame_done, sync_err, sync_err_sticky;

    frame_loader_if #(.COLS(COLS)) bus();

    frame_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .in_if           (bus),
        .frame_sync      (frame_sync),
        .mat             (mat),
        .frame_done      (frame_done),
        .sync_err        (sync_err),
        .sync_err_sticky (sync_err_sticky)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic tally(input bit ok, input string name, input string got, input string want);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s expected %s at %0t", name, got, want, $time);
        end
    endtask
    task automatic chkb(input string name, input logic act, input logic exp);
        tally(act === exp, name, $sformatf("%b", act), $sformatf("%b", exp));
    endtask
    task automatic chkr(input string name, input logic [0:COLS-1] act, input logic [0:COLS-1] exp);
        tally(act === exp, name, $sformatf("%h", act), $sformatf("%h", exp));
    endtask
    task automatic chkw(input string name, input logic [0:FB-1] act, input logic [0:FB-1] exp);
        tally(act === exp, name, $sformatf("%h", act), $sformatf("%h", exp));
    endtask
    task automatic chki(input string name, input int act, input int exp);
        tally(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    // Frame-level model: rows collected so far, whether a full frame awaits a sync, visible frame.
    logic [0:COLS-1] m_back [ROWS];
    int              m_cnt;
    bit              m_full;
    logic [0:FB-1]   m_mat;
    logic            m_done, m_err, m_sticky;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) m_back[r] <= '0;
            m_cnt <= 0; m_full <= 1'b0; m_mat <= '0;
            m_done <= 1'b0; m_err <= 1'b0; m_sticky <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (!m_full && bus.in_valid) begin
                if (bus.in_sof && m_cnt != 0) begin
                    m_back[0] <= bus.in_data;
                    m_cnt     <= 1;
                    m_err     <= 1'b1;
                    m_sticky  <= 1'b1;
                end else begin
                    m_back[m_cnt] <= bus.in_data;
                    m_cnt         <= (m_cnt == ROWS - 1) ? 0 : m_cnt + 1;
                    m_full        <= (m_cnt == ROWS - 1);
                end
            end else if (m_full && frame_sync) begin
                for (int r = 0; r < ROWS; r++) m_mat[r*COLS +: COLS] <= m_back[r];
                m_full <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    int            done_total = 0;
    logic [0:FB-1] exp_q [$];

    always @(negedge clock) begin
        chkb("in_ready", bus.in_ready, !m_full);
        chkw("mat", mat, m_mat);
        chkb("frame_done", frame_done, m_done);
        chkb("sync_err", sync_err, m_err);
        chkb("sync_err_sticky", sync_err_sticky, m_sticky);
        if (frame_done) begin
            done_total++;
            if (exp_q.size() > 0) chkw("frame_intact", mat, exp_q.pop_front());
        end
    end

    task automatic send(input logic [0:COLS-1] d, input bit sof);
        int t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clock); t++; end
        if (!bus.in_ready) chkb("send_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = sof;
        @(negedge clock);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = COLS'($urandom);
    endtask

    task automatic send_rand(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) send(COLS'($urandom), sof_first && i == 0);
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        @(negedge clock);
        frame_sync = 1'b0;
    endtask

    logic [0:COLS-1] words [ROWS] = '{16'h2040, 16'h28A0, 16'h3510, 16'h4A08, 16'h5A04, 16'h6BF2,
                                      16'h7C01, 16'h8D11, 16'h9E22, 16'hAF33, 16'hB044, 16'hC155,
                                      16'hD266, 16'hE377, 16'hF488, 16'h0040};

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0; frame_sync = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clock);
        chkb("rst_in_ready", bus.in_ready, 1'b1);
        chkw("rst_mat", mat, '0);
        chkb("rst_sticky", sync_err_sticky, 1'b0);
        rst_n = 1'b1;
        @(negedge clock);

        // Fixed frame: after 16 words the loader must stall with the front still blank.
        for (int r = 0; r < ROWS; r++) send(words[r], r == 0);
        chkb("full_in_ready", bus.in_ready, 1'b0);
        chkw("full_mat_blank", mat, '0);
        pulse_sync();
        chkr("swap_row0", mat[0:15], 16'h2040);
        chkr("swap_row15", mat[240:255], 16'h0040);
        chkb("swap_done", frame_done, 1'b1);
        chkb("swap_ready", bus.in_ready, 1'b1);
        @(negedge clock);
        chkb("done_one_cycle", frame_done, 1'b0);

        // Mid-frame sof discards the partial frame.
        send_rand(5, 1'b1);
        send(16'hFFFF, 1'b1);
        chkb("err_pulse", sync_err, 1'b1);
        chkb("err_sticky", sync_err_sticky, 1'b1);
        send_rand(15, 1'b0);
        pulse_sync();
        chkr("err_row0", mat[0:15], 16'hFFFF);

        // frame_sync during FILL is ignored.
        send_rand(7, 1'b1);
        base = done_total;
        frame_sync = 1'b1;
        repeat (20) @(negedge clock);
        frame_sync = 1'b0;
        chki("fill_sync_no_done", done_total - base, 0);
        send_rand(9, 1'b0);
        pulse_sync();

        // Asynchronous reset while a full frame is pending.
        send_rand(ROWS, 1'b1);
        chkb("pend_ready", bus.in_ready, 1'b0);
        @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        chkw("async_rst_mat", mat, '0);
        chkb("async_rst_ready", bus.in_ready, 1'b1);
        @(negedge clock);
        rst_n = 1'b1;
        base = done_total;
        pulse_sync();
        @(negedge clock);
        chki("post_rst_no_done", done_total - base, 0);
        chkw("post_rst_mat", mat, '0);

        // Three back-to-back frames with random valid gaps and periodic frame_sync.
        base = done_total;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    logic [0:FB-1]   fr;
                    logic [0:COLS-1] w;
                    fr = '0;
                    for (int r = 0; r < ROWS; r++) begin
                        w = COLS'($urandom);
                        repeat ($urandom_range(0, 2)) @(negedge clock);
                        fr[r*COLS +: COLS] = w;
                        if (r == ROWS - 1) exp_q.push_back(fr);
                        send(w, r == 0);
                    end
                end
            end
            begin
                int cyc = 0;
                while (done_total - base < 3 && cyc < 3000) begin
                    repeat (39) @(negedge clock);
                    pulse_sync();
                    cyc += 40;
                end
            end
        join
        @(negedge clock);
        chki("stream_done_count", done_total - base, 3);
        chki("stream_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
